// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller.
// State encoding, error codes and the default header byte.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CSUM,
      S_HOLD
   } state_e;

   localparam logic [1:0] ERR_OVR  = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_CSUM = 2'b10;
   localparam logic [1:0] ERR_TO   = 2'b11;

   localparam logic [7:0] HDR_DEF  = 8'h55;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload RAM: single write port, registered read port.
// Reads at or beyond the held frame length return zero.
module uart_frame_buf #(
   parameter int MAX_LEN = 16,
   parameter int LW      = $clog2(MAX_LEN + 1),
   parameter int AW      = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] rd_addr_i,
   input  logic [LW-1:0] rd_lim_i,
   output logic [7:0]    rd_data_o
);

   logic [7:0] mem [MAX_LEN];
   logic [7:0] rd_q;

   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= 8'h00;
      else if (LW'(rd_addr_i) < rd_lim_i) rd_q <= mem[rd_addr_i];
      else rd_q <= 8'h00;
   end

   assign rd_data_o = rd_q;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Parses HDR/CMD/LEN/payload/checksum frames from a UART byte stream.
// Optional inter-byte timeout enabled by UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter logic [7:0] HDR      = HDR_DEF,
   parameter int         MAX_LEN  = 16,
   parameter int         BPS      = 5208,
   parameter int         TO_BYTES = 4,
   localparam int        LW       = $clog2(MAX_LEN + 1),
   localparam int        AW       = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          frm_valid,
   output logic [7:0]    frm_cmd,
   output logic [LW-1:0] frm_len,
   input  logic          frm_ack,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          frm_err,
   output logic [1:0]    err_code,
   output logic          busy
);

   state_e        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [LW-1:0] len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [7:0]    fcmd_q, fcmd_d;
   logic [LW-1:0] flen_q, flen_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic          we;

`ifdef UART_FRAME_TIMEOUT_EN
   localparam int TO_CYC = BPS * 10 * TO_BYTES;
   localparam int TW     = $clog2(TO_CYC + 1);
   logic [TW-1:0] to_q, to_d;
   logic          timed;
`endif

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      fcmd_d  = fcmd_q;
      flen_d  = flen_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      code_d  = code_q;
      we      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_valid && rx_data == HDR) state_d = S_CMD;
         end
         S_CMD: begin
            if (rx_valid) begin
               cmd_d   = rx_data;
               sum_d   = rx_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               sum_d = sum_q + rx_data;
               len_d = LW'(rx_data);
               idx_d = '0;
               if (32'(rx_data) > MAX_LEN) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = S_IDLE;
               end else if (rx_data == 8'h00) begin
                  state_d = S_CSUM;
               end else begin
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               we    = 1'b1;
               sum_d = sum_q + rx_data;
               if (LW'(idx_q) == len_q - LW'(1)) begin
                  idx_d   = '0;
                  state_d = S_CSUM;
               end else begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data == sum_q) begin
                  fcmd_d  = cmd_q;
                  flen_d  = len_q;
                  valid_d = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CSUM;
                  state_d = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            // Ack frees the slot this cycle, so a concurrent HDR starts a frame.
            if (frm_ack) begin
               valid_d = 1'b0;
               if (rx_valid && rx_data == HDR) state_d = S_CMD;
               else state_d = S_IDLE;
            end else if (rx_valid) begin
               err_d  = 1'b1;
               code_d = ERR_OVR;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef UART_FRAME_TIMEOUT_EN
      timed = (state_q == S_CMD) || (state_q == S_LEN) ||
              (state_q == S_PAYLOAD) || (state_q == S_CSUM);
      to_d  = (rx_valid || !timed) ? '0 : to_q + TW'(1);
      if (timed && !rx_valid && to_q == TW'(TO_CYC - 1)) begin
         err_d   = 1'b1;
         code_d  = ERR_TO;
         state_d = S_IDLE;
         to_d    = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= 8'h00;
         len_q   <= '0;
         sum_q   <= 8'h00;
         idx_q   <= '0;
         fcmd_q  <= 8'h00;
         flen_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         fcmd_q  <= fcmd_d;
         flen_q  <= flen_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

`ifdef UART_FRAME_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) to_q <= '0;
      else to_q <= to_d;
   end
`endif

   uart_frame_buf #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW),
      .AW      (AW)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (we),
      .waddr_i   (idx_q),
      .wdata_i   (rx_data),
      .rd_addr_i (rd_addr),
      .rd_lim_i  (flen_q),
      .rd_data_o (rd_data)
   );

   assign frm_valid = valid_q;
   assign frm_cmd   = fcmd_q;
   assign frm_len   = flen_q;
   assign frm_err   = err_q;
   assign err_code  = code_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Randomized scoreboard bench for uart_frame_ctrl.
// Timeout branch follows UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int BPS     = 2;
   localparam int TOB     = 1;
   localparam int TO_CYC  = BPS * 10 * TOB;
   localparam int LW      = $clog2(MAX_LEN + 1);
   localparam int AW      = $clog2(MAX_LEN);

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          frm_valid;
   logic [7:0]    frm_cmd;
   logic [LW-1:0] frm_len;
   logic          frm_ack;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data;
   logic          frm_err;
   logic [1:0]    err_code;
   logic          busy;

   always #5 clk = ~clk;

   uart_frame_ctrl #(
      .HDR      (8'h55),
      .MAX_LEN  (MAX_LEN),
      .BPS      (BPS),
      .TO_BYTES (TOB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frm_valid (frm_valid),
      .frm_cmd   (frm_cmd),
      .frm_len   (frm_len),
      .frm_ack   (frm_ack),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .frm_err   (frm_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   typedef struct {
      bit           is_err;
      logic [1:0]   code;
      logic [7:0]   cmd;
      int           len;
      logic [127:0] pl;
   } ev_t;

   ev_t          exq[$];
   ev_t          m_e;
   int           n_chk = 0;
   int           n_pass = 0;
   logic [7:0]   held_cmd;
   int           held_len;
   logic [127:0] held_pl;
   bit           vp;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   initial begin
      vp = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            vp = 0;
         end else begin
            if (frm_err) begin
               if (exq.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexp_err: got code %0d expected none",
                           err_code);
               end else begin
                  m_e = exq.pop_front();
                  if (!m_e.is_err) begin
                     n_chk++;
                     $display("FAIL ev_kind: got err %0d expected frame",
                              err_code);
                  end else chk("err_code", 32'(err_code), 32'(m_e.code));
               end
            end
            if (frm_valid && !vp) begin
               if (exq.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexp_frame: got cmd %0h expected none",
                           frm_cmd);
               end else begin
                  m_e = exq.pop_front();
                  if (m_e.is_err) begin
                     n_chk++;
                     $display("FAIL ev_kind: got frame expected err %0d",
                              m_e.code);
                  end else begin
                     chk("frm_cmd", 32'(frm_cmd), 32'(m_e.cmd));
                     chk("frm_len", 32'(frm_len), m_e.len);
                     held_cmd = m_e.cmd;
                     held_len = m_e.len;
                     held_pl  = m_e.pl;
                  end
               end
            end
            vp = frm_valid;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic push_err(input logic [1:0] c);
      ev_t e;
      e.is_err = 1;
      e.code   = c;
      e.cmd    = 8'h00;
      e.len    = 0;
      e.pl     = '0;
      exq.push_back(e);
   endtask

   task automatic push_frame(input logic [7:0] c, input int l,
                             input logic [127:0] p);
      ev_t e;
      e.is_err = 0;
      e.code   = 2'b00;
      e.cmd    = c;
      e.len    = l;
      e.pl     = p;
      exq.push_back(e);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !frm_valid; i++) @(negedge clk);
      chk("valid_wait", 32'(frm_valid), 1);
   endtask

   task automatic sweep();
      logic [7:0] ex;
      @(negedge clk);
      for (int a = 0; a < MAX_LEN; a++) begin
         rd_addr = AW'(a);
         @(negedge clk);
         ex = (a < held_len) ? held_pl[a*8 +: 8] : 8'h00;
         chk($sformatf("rd_data[%0d]", a), 32'(rd_data), 32'(ex));
      end
   endtask

   task automatic do_ack();
      frm_ack = 1'b1;
      @(negedge clk);
      frm_ack = 1'b0;
      chk("ack_drop", 32'(frm_valid), 0);
      chk("cmd_keep", 32'(frm_cmd), 32'(held_cmd));
      chk("ack_busy", 32'(busy), 0);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input int len,
                             input logic [127:0] pl,
                             input logic [7:0] cx, input bit rand_gap);
      int s;
      logic [7:0] cs;
      int g;
      g = rand_gap ? 2 : 0;
      if (len > MAX_LEN) begin
         push_err(2'b01);
         send_byte(8'h55, $urandom_range(0, g));
         send_byte(cmd, $urandom_range(0, g));
         send_byte(8'(len), 3);
         return;
      end
      s = cmd + len;
      for (int i = 0; i < len; i++) s += pl[i*8 +: 8];
      cs = 8'(s % 256) ^ cx;
      if (cx != 8'h00) push_err(2'b10);
      else push_frame(cmd, len, pl);
      send_byte(8'h55, $urandom_range(0, g));
      send_byte(cmd, $urandom_range(0, g));
      send_byte(8'(len), $urandom_range(0, g));
      for (int i = 0; i < len; i++)
         send_byte(pl[i*8 +: 8], $urandom_range(0, g));
      send_byte(cs, 0);
      if (cx == 8'h00) begin
         wait_valid();
         sweep();
         do_ack();
      end else begin
         repeat (3) @(negedge clk);
         chk("err_busy", 32'(busy), 0);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(frm_valid), 0);
      chk("rst_cmd", 32'(frm_cmd), 0);
      chk("rst_len", 32'(frm_len), 0);
      chk("rst_rd", 32'(rd_data), 0);
      chk("rst_err", 32'(frm_err), 0);
      chk("rst_code", 32'(err_code), 0);
      chk("rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] p;
      logic [7:0] b;
      int l;
      rst_n    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      frm_ack  = 1'b0;
      rd_addr  = '0;
      reset_pulse();

      p = '0;
      p[7:0]  = 8'hAA;
      p[15:8] = 8'hBB;
      send_frame(8'h01, 2, p, 8'h00, 0);
      send_frame(8'h01, 2, p, 8'h01, 0);
      send_frame(8'h01, 2, p, 8'h00, 0);
      send_frame(8'h07, 17, '0, 8'h00, 0);
      send_frame(8'h07, 0, '0, 8'h00, 0);

      push_frame(8'h01, 2, p);
      send_byte(8'h55, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      send_byte(8'h68, 0);
      wait_valid();
      for (int i = 0; i < 3; i++) begin
         push_err(2'b00);
         b = (i == 0) ? 8'h55 : 8'($urandom);
         send_byte(b, 0);
      end
      repeat (2) @(negedge clk);
      sweep();
      frm_ack  = 1'b1;
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      @(negedge clk);
      frm_ack  = 1'b0;
      rx_valid = 1'b0;
      chk("ackhdr_busy", 32'(busy), 1);
      p = '0;
      p[7:0] = 8'hCC;
      push_frame(8'h03, 1, p);
      send_byte(8'h03, 0);
      send_byte(8'h01, 0);
      send_byte(8'hCC, 0);
      send_byte(8'hD0, 0);
      wait_valid();
      sweep();
      do_ack();

`ifdef UART_FRAME_TIMEOUT_EN
      push_err(2'b11);
`endif
      send_byte(8'h55, 0);
      send_byte(8'h01, 0);
      repeat (TO_CYC + 10) @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
      chk("to_busy", 32'(busy), 0);
`else
      chk("to_busy", 32'(busy), 1);
      reset_pulse();
`endif

      send_byte(8'h55, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      send_byte(8'hAA, 0);
      reset_pulse();
      p = '0;
      p[7:0]  = 8'hAA;
      p[15:8] = 8'hBB;
      send_frame(8'h01, 2, p, 8'h00, 0);

      for (int n = 0; n < 40; n++) begin
         for (int j = $urandom_range(0, 2); j > 0; j--) begin
            b = 8'($urandom);
            if (b == 8'h55) b = 8'h54;
            send_byte(b, $urandom_range(0, 2));
         end
         p = {$urandom, $urandom, $urandom, $urandom};
         l = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 255)
                                         : $urandom_range(0, MAX_LEN);
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255))
                                         : 8'h00;
         send_frame(8'($urandom), l, p, b, 1);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", exq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
